// File: rtl/divu_pkg.sv
// divu_pkg: function codes, FSM state encoding and constants shared by the divider.
package divu_pkg;
   localparam int WIDTH = 32;
   localparam logic [5:0] DIVU = 6'b011011;
   localparam logic [5:0] DIV  = 6'b011010;
   localparam logic [WIDTH-1:0] DIV0_QUOT = '1;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/divu_step.sv
// divu_step: one radix-2 restoring shift-subtract iteration on {R,Q} against D.
module divu_step #(
   parameter int W = 32
) (
   input  logic [W:0]   r,
   input  logic [W-1:0] q,
   input  logic [W-1:0] d,
   output logic [W:0]   r_nxt,
   output logic [W-1:0] q_nxt
);
   logic [2*W:0] sh;
   logic [W:0]   trial;
   always_comb begin
      sh    = {r, q} << 1;
      trial = sh[2*W:W] - {1'b0, d};
      r_nxt = trial[W] ? sh[2*W:W] : trial;
      q_nxt = sh[W-1:0] | {{(W-1){1'b0}}, ~trial[W]};
   end
endmodule

// File: rtl/divu_sequencer.sv
// divu_sequencer: multi-cycle unsigned divider producing {remainder, quotient} for HiLo.
// Defining DIVU_SIGNED_EN adds signed division started by DIV_CODE.
module divu_sequencer #(
   parameter int         WIDTH     = divu_pkg::WIDTH,
   parameter logic [5:0] DIVU_CODE = divu_pkg::DIVU,
   parameter logic [5:0] DIV_CODE  = divu_pkg::DIV
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     dataA,
   input  logic [WIDTH-1:0]     dataB,
   input  logic [5:0]           Signal,
   output logic [2*WIDTH-1:0]   dataOut,
   output logic                 busy,
   output logic                 done
);
   import divu_pkg::*;
   localparam int CW = $clog2(WIDTH);
`ifdef DIVU_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif
   state_t               state_q, state_d;
   logic [WIDTH:0]       r_q, r_d, r_nxt;
   logic [WIDTH-1:0]     q_q, q_d, d_q, d_d, q_nxt;
   logic [WIDTH-1:0]     a_in, b_in, q_res, r_res;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   out_q, out_d;
   logic                 is_div, start;
   assign is_div = SIGNED_EN && Signal == DIV_CODE;
   assign start  = state_q == IDLE && (Signal == DIVU_CODE || is_div);
   divu_step #(.W(WIDTH)) u_step (
      .r     (r_q),
      .q     (q_q),
      .d     (d_q),
      .r_nxt (r_nxt),
      .q_nxt (q_nxt)
   );
`ifdef DIVU_SIGNED_EN
   logic sq_q, sq_d, sr_q, sr_d;
   // The loop runs on magnitudes; signs are reapplied as the result is registered.
   always_comb begin
      a_in  = (is_div && dataA[WIDTH-1]) ? -dataA : dataA;
      b_in  = (is_div && dataB[WIDTH-1]) ? -dataB : dataB;
      sq_d  = start ? is_div && (dataA[WIDTH-1] ^ dataB[WIDTH-1]) : sq_q;
      sr_d  = start ? is_div && dataA[WIDTH-1] : sr_q;
      q_res = sq_q ? -q_nxt : q_nxt;
      r_res = sr_q ? -r_nxt[WIDTH-1:0] : r_nxt[WIDTH-1:0];
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         sq_q <= 1'b0;
         sr_q <= 1'b0;
      end else begin
         sq_q <= sq_d;
         sr_q <= sr_d;
      end
   end
`else
   assign a_in  = dataA;
   assign b_in  = dataB;
   assign q_res = q_nxt;
   assign r_res = r_nxt[WIDTH-1:0];
`endif
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      case (state_q)
         IDLE: if (start) begin
            r_d     = '0;
            q_d     = a_in;
            d_d     = b_in;
            cnt_d   = '0;
            state_d = b_in == '0 ? DONE : CALC;
            out_d   = b_in == '0 ? {dataA, DIV0_QUOT} : out_q;
         end
         CALC: begin
            r_d   = r_nxt;
            q_d   = q_nxt;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               out_d   = {r_res, q_res};
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
      end
   end
   assign dataOut = out_q;
   assign busy    = state_q != IDLE;
   assign done    = state_q == DONE;
endmodule

// File: tb/tb_divu_sequencer.sv
// tb_divu_sequencer: directed and random divides checked against an arithmetic reference.
module tb_divu_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] dataA = '0;
   logic [31:0] dataB = '0;
   logic [5:0]  Signal = '0;
   logic [63:0] dataOut;
   logic        busy, done;
   int checks = 0;
   int failures = 0;

   divu_sequencer dut (
      .clk     (clk),
      .reset   (reset),
      .dataA   (dataA),
      .dataB   (dataB),
      .Signal  (Signal),
      .dataOut (dataOut),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_divu(input logic [31:0] a, input logic [31:0] b);
      return b == 0 ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Start at one edge, watch busy until done, then check latency, result and return to idle.
   // At cycle poke a second DIVU request with 9/3 is driven while the first is still running.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sig,
                          input logic [63:0] exp, input int exp_lat, input string tag, input int poke);
      int lat;
      logic busy_all;
      @(negedge clk);
      dataA = a; dataB = b; Signal = sig;
      @(negedge clk);
      Signal = 6'd0; dataA = $urandom; dataB = $urandom;
      lat = 1; busy_all = 1'b1;
      while (!done && lat < 40) begin
         busy_all &= busy;
         if (lat == poke) begin
            Signal = 6'd27; dataA = 32'd9; dataB = 32'd3;
         end else begin
            Signal = 6'd0;
         end
         @(negedge clk);
         lat++;
      end
      busy_all &= busy;
      Signal = 6'd0;
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_busy"}, 64'(busy_all), 64'd1);
      check({tag, "_data"}, dataOut, exp);
      @(negedge clk);
      check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
      check({tag, "_hold"}, dataOut, exp);
   endtask

   initial begin
      int d1, d2;
      logic [31:0] a, b;
      logic [63:0] last;
      repeat (2) @(negedge clk);
      check("reset_out", {dataOut, 62'd0, busy, done} >> 2, 64'd0);
      check("reset_flags", {62'd0, busy, done}, 64'd0);
      reset = 1'b1;

      run_div(32'd100, 32'd7, 6'd27, {32'd2, 32'd14}, 33, "d100_7", 0);
      run_div(32'hFFFF_FFFF, 32'd1, 6'd27, {32'd0, 32'hFFFF_FFFF}, 33, "dmax_1", 0);
      run_div(32'd5, 32'hFFFF_FFFF, 6'd27, {32'd5, 32'd0}, 33, "d5_max", 0);
      run_div(32'd5, 32'd0, 6'd27, {32'd5, 32'hFFFF_FFFF}, 1, "d5_0", 0);
      run_div(32'd100, 32'd7, 6'd27, {32'd2, 32'd14}, 33, "restart_ign", 10);

      // Unrelated codes in IDLE must not start anything.
      @(negedge clk);
      dataA = 32'd50; dataB = 32'd5; Signal = 6'd24;
      repeat (3) @(negedge clk);
      Signal = 6'd0;
      check("other_code", {dataOut[61:0], busy, done}, {ref_divu(32'd100, 32'd7)} << 2);

      // Reset mid-CALC abandons the divide and clears the result register.
      @(negedge clk);
      dataA = 32'd100; dataB = 32'd7; Signal = 6'd27;
      @(negedge clk);
      Signal = 6'd0;
      repeat (9) @(negedge clk);
      check("mid_busy", 64'(busy), 64'd1);
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_out", dataOut, 64'd0);
      check("rst_mid_flags", {62'd0, busy, done}, 64'd0);
      reset = 1'b1;
      run_div(32'd9, 32'd3, 6'd27, {32'd0, 32'd3}, 33, "d9_3", 0);

      // Request held high: the next start is taken one edge after done is seen.
      @(negedge clk);
      dataA = 32'd100; dataB = 32'd7; Signal = 6'd27;
      d1 = 0; d2 = 0;
      for (int lat = 1; lat <= 70; lat++) begin
         @(negedge clk);
         if (done) begin
            if (d1 == 0) d1 = lat;
            else if (d2 == 0) begin
               d2 = lat;
               Signal = 6'd0;
            end
         end
      end
      Signal = 6'd0;
      check("back2back_1", 64'(d1), 64'd33);
      check("back2back_2", 64'(d2), 64'd67);
      check("back2back_idle", {62'd0, busy, done}, 64'd0);

      for (int i = 0; i < 8; i++) begin
         a = $urandom;
         b = (i % 2 == 1) ? $urandom : $urandom_range(1, 255);
         if (i == 3) b = 32'd0;
         if (i == 5) a = $urandom_range(0, 3);
         run_div(a, b, 6'd27, ref_divu(a, b), b == 0 ? 1 : 33, $sformatf("rnd%0d", i), 0);
      end
      last = ref_divu(a, b);

`ifdef DIVU_SIGNED_EN
      run_div(-32'sd7, 32'sd2, 6'd26, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "sdiv_m7_2", 0);
      run_div(32'sd7, -32'sd2, 6'd26, {32'd1, 32'hFFFF_FFFD}, 33, "sdiv_7_m2", 0);
      run_div(-32'sd9, 32'sd0, 6'd26, {-32'sd9, 32'hFFFF_FFFF}, 1, "sdiv_div0", 0);
      for (int i = 0; i < 4; i++) begin
         int sa, sb;
         sa = int'($urandom) >>> 4;
         sb = int'($urandom_range(1, 1000)) * ((i % 2 == 0) ? -1 : 1);
         run_div(sa, sb, 6'd26, {32'(sa % sb), 32'(sa / sb)}, 33, $sformatf("srnd%0d", i), 0);
      end
`else
      @(negedge clk);
      dataA = -32'sd7; dataB = 32'sd2; Signal = 6'd26;
      repeat (3) @(negedge clk);
      check("div_ignored_busy", 64'(busy), 64'd0);
      @(negedge clk);
      Signal = 6'd0;
      check("div_ignored_out", dataOut, last);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/divu_sequencer.md
# divu_sequencer

Multi-cycle 32-bit unsigned divider executing the DIVU function (Signal = 27) of the ALU datapath. It complements the multiplier on the HiLo path: it takes dataA/dataB plus the 6-bit function code and computes quotient and remainder with a radix-2 restoring shift-subtract loop, one bit per cycle. It then presents a 64-bit {remainder, quotient} word for the HiLo register to capture into Hi/Lo.

## Interface
Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- DIVU_CODE, 6'b011011, function code that starts an unsigned divide.
- DIV_CODE, 6'b011010, function code that starts a signed divide (used only with DIVU_SIGNED_EN).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- dataA  in  32  dividend; sampled only on the start edge.
- dataB  in  32  divisor; sampled only on the start edge.
- Signal  in  6  function code from ALU control.
- dataOut  out  64  {remainder[63:32], quotient[31:0]}; registered.
- busy  out  1  high while an operation is in progress or completing.
- done  out  1  single-cycle pulse when dataOut holds a new result.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, Signal == DIVU_CODE at a clk edge: capture dataA into Q and dataB into D, clear the 33-bit partial remainder R, clear the 5-bit counter.
  - Next state is CALC.
  - If dataB == 0, the next state is DONE instead.
- Other Signal codes in IDLE are ignored.
- CALC, each edge performs one step:
  - shift {R,Q} left by 1;
  - trial = R - {1'b0, D};
  - if trial[32] == 0, then R = trial and Q[0] = 1; otherwise R is unchanged and Q[0] = 0.
  - count increments. After the step with count == 31, the next state is DONE.
- DONE lasts exactly one cycle:
  - dataOut = {R[31:0], Q};
  - done = 1;
  - next state is IDLE.
- dataOut holds its value until the next DONE or reset.
- Divide by zero: quotient = 32'hFFFF_FFFF and remainder = dataA, produced in DONE with no CALC cycles.
- Signal == DIVU_CODE while busy: ignored. There is no queueing and no restart.
- Operands changing after the start edge: no effect on the result.

## Timing
- Reset (reset == 0 at a clk edge):
  - state = IDLE; R, Q, D and count cleared;
  - dataOut = 64'h0, busy = 0, done = 0;
  - this takes priority over everything, including an operation mid-CALC, which is abandoned.
- Start edge E0: busy = 1 from E0 onward.
- Normal divide: 32 CALC edges (E1..E32). DONE is entered at E32, so done = 1 and dataOut is valid in the cycle after E32.
  - Latency from the start edge to done: 33 cycles.
  - busy falls at E33.
- Divide by zero: DONE is entered at E0, so done is high in the cycle after E0 (latency 1).
- The earliest next start is the edge at which done = 1 is sampled (E33), because the state is IDLE from E33.
  - A start at that edge is recognised one edge later. The requirement is stated precisely: a start is accepted only when state == IDLE before the edge.
- Arithmetic: all unsigned, modulo 2^32. R is 33 bits so the sign of trial is observable.

## Configuration
- DIVU_SIGNED_EN defined: Signal == DIV_CODE also starts an operation.
  - On the start edge, operand magnitudes are captured and the sign flags sq = A[31]^B[31] and sr = A[31] are recorded.
  - In DONE, Q is negated if sq and R is negated if sr (quotient truncates toward zero; remainder takes the dividend's sign).
  - Signed divide by zero: quotient = 32'hFFFF_FFFF, remainder = dataA.
  - Latency is identical to unsigned.
- DIVU_SIGNED_EN undefined: DIV_CODE is ignored like any other code, and the sign logic and flags are absent.

## Structure
- Shared package divu_pkg holds:
  - function codes DIVU = 6'b011011 and DIV = 6'b011010;
  - the state encoding (IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2);
  - WIDTH = 32 and the divide-by-zero quotient constant.
- One combinational sub-module, divu_step: inputs R, Q, D; outputs the next R and Q for one restoring iteration.
- The FSM, counter, sign handling and output register live in the top level.

## Test plan
- 100 / 7 via Signal = 27 -> done pulses 33 cycles after the start edge; dataOut = {32'd2, 32'd14}; busy = 1 throughout, 0 after.
- 32'hFFFF_FFFF / 1 -> dataOut = {32'h0, 32'hFFFF_FFFF}. Then 5 / 32'hFFFF_FFFF -> {32'd5, 32'd0}.
- 5 / 0 -> done in the cycle after the start edge; dataOut = {32'd5, 32'hFFFF_FFFF}.
- Start 100 / 7, then drive Signal = 27 with 9 / 3 at cycle 10 -> the second request is ignored; the result is still {2, 14} at cycle 33.
- Start 100 / 7, assert reset = 0 at cycle 10 -> dataOut = 0, busy = 0, done = 0. After release, 9 / 3 -> {32'd0, 32'd3} after 33 cycles.
- With DIVU_SIGNED_EN: -7 / 2 (Signal = 26) -> dataOut = {32'hFFFF_FFFF, 32'hFFFF_FFFD}. Without the macro, the same stimulus leaves busy = 0 and dataOut unchanged.
